// File: rtl/div_issue_ctrl.sv
// EX-stage issue controller for the iterative divider: stalls EX, launches the divider and returns the result.
// Optional last-result cache enabled by defining DIV_RESULT_CACHE_EN.
module div_issue_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] req_rs1,
  input  logic [WIDTH-1:0] req_rs2,
  input  logic             flush,
  output logic             stall,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_data,
  output logic             div_start,
  output logic [WIDTH-1:0] div_dividend,
  output logic [WIDTH-1:0] div_divisor,
  output logic             div_sign,
  input  logic             div_busy,
  input  logic [WIDTH-1:0] div_quotient,
  input  logic [WIDTH-1:0] div_remainder
);

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE, S_DRAIN} state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_op_rem;
  logic             r_div_start;
  logic             r_div_sign;
  logic [WIDTH-1:0] r_dividend;
  logic [WIDTH-1:0] r_divisor;
  logic [WIDTH-1:0] r_result;

  logic             w_accept;
  logic             w_div_zero;
  logic             w_ovf;
  logic             w_hit;
  logic             w_fast;
  logic             w_capture;
  logic [WIDTH-1:0] w_fast_res;

  assign w_accept   = (r_state == S_IDLE) & req_valid & ~flush;
  assign w_div_zero = (req_rs2 == '0);
  assign w_ovf      = ~req_op[0] & (req_rs1 == MIN_NEG) & (req_rs2 == '1);
  assign w_fast     = w_div_zero | w_ovf | w_hit;
  assign w_capture  = (r_state == S_WAIT) & ~flush & ~div_busy;

`ifdef DIV_RESULT_CACHE_EN
  logic             r_c_valid;
  logic             r_c_sign;
  logic [WIDTH-1:0] r_c_rs1;
  logic [WIDTH-1:0] r_c_rs2;
  logic [WIDTH-1:0] r_c_quot;
  logic [WIDTH-1:0] r_c_rem;

  assign w_hit = r_c_valid & (r_c_rs1 == req_rs1) & (r_c_rs2 == req_rs2)
               & (r_c_sign == ~req_op[0]);

  // Only completed, non-flushed divider runs are remembered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_c_valid <= 1'b0;
      r_c_sign  <= 1'b0;
      r_c_rs1   <= '0;
      r_c_rs2   <= '0;
      r_c_quot  <= '0;
      r_c_rem   <= '0;
    end else if (w_capture) begin
      r_c_valid <= 1'b1;
      r_c_sign  <= r_div_sign;
      r_c_rs1   <= r_dividend;
      r_c_rs2   <= r_divisor;
      r_c_quot  <= div_quotient;
      r_c_rem   <= div_remainder;
    end
  end
`else
  assign w_hit = 1'b0;
`endif

  always_comb begin
    w_fast_res = '0;
    if (w_div_zero) begin
      w_fast_res = req_op[1] ? req_rs1 : '1;
    end else if (w_ovf) begin
      w_fast_res = req_op[1] ? '0 : MIN_NEG;
    end
`ifdef DIV_RESULT_CACHE_EN
    else if (w_hit) begin
      w_fast_res = req_op[1] ? r_c_rem : r_c_quot;
    end
`endif
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = w_fast ? S_DONE : S_ISSUE;
      S_ISSUE: w_next = flush ? S_DRAIN : S_WAIT;
      S_WAIT: begin
        if (flush)          w_next = S_DRAIN;
        else if (!div_busy) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      // The divider cannot be aborted, so let it run out before accepting again.
      S_DRAIN: if (!div_busy) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_op_rem    <= 1'b0;
      r_div_start <= 1'b0;
      r_div_sign  <= 1'b0;
      r_dividend  <= '0;
      r_divisor   <= '0;
      r_result    <= '0;
    end else begin
      r_state     <= w_next;
      r_div_start <= w_accept & ~w_fast;
      // Operands only change on a launch so they stay stable for the whole divider run.
      if (w_accept && !w_fast) begin
        r_op_rem   <= req_op[1];
        r_div_sign <= ~req_op[0];
        r_dividend <= req_rs1;
        r_divisor  <= req_rs2;
      end
      if (w_accept && w_fast) begin
        r_result <= w_fast_res;
      end else if (w_capture) begin
        r_result <= r_op_rem ? div_remainder : div_quotient;
      end
    end
  end

  assign stall        = req_valid & (r_state != S_DONE) & ~rst;
  assign res_valid    = (r_state == S_DONE);
  assign res_data     = r_result;
  assign div_start    = r_div_start;
  assign div_dividend = r_dividend;
  assign div_divisor  = r_divisor;
  assign div_sign     = r_div_sign;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed bench for div_issue_ctrl with a behavioural divider and a result/timing model.
module tb_div_issue_ctrl;
  localparam int W = 32;
  localparam logic [W-1:0] MINV = 32'h8000_0000;
`ifdef DIV_RESULT_CACHE_EN
  localparam bit CACHE_EN = 1'b1;
`else
  localparam bit CACHE_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic [1:0]   req_op;
  logic [W-1:0] req_rs1, req_rs2;
  logic         flush;
  logic         stall, res_valid, div_start, div_sign;
  logic [W-1:0] res_data, div_dividend, div_divisor;
  logic         div_busy;
  logic [W-1:0] div_quotient, div_remainder;

  always #5 clk = ~clk;

  div_issue_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .flush(flush),
    .stall(stall), .res_valid(res_valid), .res_data(res_data),
    .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_sign(div_sign), .div_busy(div_busy),
    .div_quotient(div_quotient), .div_remainder(div_remainder)
  );

  // Behavioural divider: busy for 33 cycles after start, results from operands at the end.
  function automatic logic [2*W-1:0] dv_calc(input logic [W-1:0] a, b, input logic s);
    logic [W-1:0] q, r;
    if (b == '0) begin
      q = '1; r = a;
    end else if (s) begin
      q = $signed(a) / $signed(b); r = $signed(a) % $signed(b);
    end else begin
      q = a / b; r = a % b;
    end
    return {q, r};
  endfunction

  int dv_cnt;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      div_busy <= 1'b0; dv_cnt <= 0; div_quotient <= '0; div_remainder <= '0;
    end else if (div_start) begin
      div_busy <= 1'b1; dv_cnt <= 32;
    end else if (div_busy) begin
      if (dv_cnt == 0) begin
        div_busy <= 1'b0;
        {div_quotient, div_remainder} <= dv_calc(div_dividend, div_divisor, div_sign);
      end else begin
        dv_cnt <= dv_cnt - 1;
      end
    end
  end

  // RISC-V M-extension result rules.
  function automatic logic [W-1:0] rv_result(input logic [1:0] op, input logic [W-1:0] a, b);
    logic [W-1:0] q, r;
    if (b == '0) begin
      q = '1; r = a;
    end else if (!op[0] && a == MINV && b == '1) begin
      q = MINV; r = '0;
    end else if (!op[0]) begin
      q = $signed(a) / $signed(b); r = $signed(a) % $signed(b);
    end else begin
      q = a / b; r = a % b;
    end
    return op[1] ? r : q;
  endfunction

  int n_vec = 0, n_miss = 0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  logic         chk_en = 1'b0;
  logic         exp_stall = 1'b0, exp_res_valid = 1'b0, exp_start = 1'b0, exp_ops = 1'b0;
  logic [W-1:0] exp_data = '0, exp_a = '0, exp_b = '0;
  logic         exp_sgn = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall", W'(stall), W'(exp_stall));
      chk("res_valid", W'(res_valid), W'(exp_res_valid));
      chk("div_start", W'(div_start), W'(exp_start));
      if (exp_res_valid) chk("res_data", res_data, exp_data);
      if (exp_ops) begin
        chk("div_dividend", div_dividend, exp_a);
        chk("div_divisor", div_divisor, exp_b);
        chk("div_sign", W'(div_sign), W'(exp_sgn));
      end
    end
  end

  // Cache model: last completed, non-flushed divider run.
  bit           mc_valid = 1'b0;
  bit           mc_sign;
  logic [W-1:0] mc_a, mc_b;

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic set_idle();
    req_valid = 1'b0; flush = 1'b0;
    exp_stall = 1'b0; exp_res_valid = 1'b0; exp_start = 1'b0; exp_ops = 1'b0;
  endtask

  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, b, input logic [W-1:0] lit);
    bit special, hit;
    int lat;
    special = (b == '0) || (!op[0] && a == MINV && b == '1);
    hit = CACHE_EN && mc_valid && mc_a == a && mc_b == b && mc_sign == !op[0];
    lat = (special || hit) ? 1 : 36;
    exp_data = rv_result(op, a, b);
    exp_a = a; exp_b = b; exp_sgn = !op[0];
    for (int c = 0; c <= lat; c++) begin
      req_valid = 1'b1; req_op = op; req_rs1 = a; req_rs2 = b; flush = 1'b0;
      exp_stall = (c < lat); exp_res_valid = (c == lat);
      exp_start = (lat == 36 && c == 1);
      exp_ops = (lat == 36 && c >= 1 && c < lat);
      @(negedge clk);
      if (c == lat) chk("literal", res_data, lit);
      next_cycle();
    end
    set_idle();
    @(negedge clk);
    next_cycle();
    if (lat == 36) begin
      mc_valid = 1'b1; mc_a = a; mc_b = b; mc_sign = !op[0];
    end
    $display("op=%0d rs1=%h rs2=%h expect=%h latency=%0d", op, a, b, lit, lat);
  endtask

  initial begin
    rst = 1'b1; req_op = 2'b00; req_rs1 = '0; req_rs2 = '0;
    set_idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", W'(stall), '0);
    chk("rst_res_valid", W'(res_valid), '0);
    chk("rst_res_data", res_data, '0);
    chk("rst_div_start", W'(div_start), '0);
    chk("rst_dividend", div_dividend, '0);
    chk("rst_divisor", div_divisor, '0);
    chk("rst_sign", W'(div_sign), '0);
    $display("reset state checked");
    next_cycle();
    rst = 1'b0; chk_en = 1'b1;
    next_cycle();

    run_op(2'b01, 32'd100, 32'd7, 32'd14);
    run_op(2'b11, 32'd100, 32'd7, 32'd2);
    run_op(2'b00, -32'sd7, 32'd2, 32'hFFFF_FFFD);
    run_op(2'b10, -32'sd7, 32'd2, 32'hFFFF_FFFF);
    run_op(2'b00, 32'd7, -32'sd2, 32'hFFFF_FFFD);
    run_op(2'b10, 32'd7, -32'sd2, 32'd1);
    run_op(2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF);
    run_op(2'b11, 32'd5, 32'd0, 32'd5);
    run_op(2'b01, 32'd0, 32'd0, 32'hFFFF_FFFF);
    run_op(2'b00, MINV, 32'hFFFF_FFFF, MINV);
    run_op(2'b10, MINV, 32'hFFFF_FFFF, 32'd0);
    run_op(2'b01, MINV, 32'hFFFF_FFFF, 32'd0);

    // Reset in the middle of a divider run: nothing may be emitted afterwards.
    exp_a = 32'd50; exp_b = 32'd5; exp_sgn = 1'b0;
    for (int c = 0; c < 5; c++) begin
      req_valid = 1'b1; req_op = 2'b01; req_rs1 = 32'd50; req_rs2 = 32'd5;
      exp_stall = 1'b1; exp_res_valid = 1'b0; exp_start = (c == 1); exp_ops = (c >= 1);
      next_cycle();
    end
    chk_en = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("midrst_stall", W'(stall), '0);
    chk("midrst_res_valid", W'(res_valid), '0);
    chk("midrst_res_data", res_data, '0);
    chk("midrst_div_start", W'(div_start), '0);
    chk("midrst_dividend", div_dividend, '0);
    next_cycle();
    rst = 1'b0; set_idle(); mc_valid = 1'b0; chk_en = 1'b1;
    repeat (5) next_cycle();
    $display("mid-operation reset checked");

    // Flush DIVU 100/7 at cycle 10; DIVU 9/3 arrives at cycle 20 during the drain.
    for (int c = 0; c <= 72; c++) begin
      flush = (c == 10);
      req_valid = (c <= 10) || (c >= 20);
      req_op = 2'b01;
      req_rs1 = (c <= 10) ? 32'd100 : 32'd9;
      req_rs2 = (c <= 10) ? 32'd7 : 32'd3;
      exp_stall = req_valid && (c != 72);
      exp_res_valid = (c == 72);
      exp_start = (c == 1) || (c == 37);
      exp_data = 32'd3;
      exp_ops = (c >= 1 && c <= 35) || (c >= 38 && c <= 71);
      exp_a = (c <= 35) ? 32'd100 : 32'd9;
      exp_b = (c <= 35) ? 32'd7 : 32'd3;
      exp_sgn = 1'b0;
      @(negedge clk);
      if (c == 72) chk("flush_literal", res_data, 32'd3);
      next_cycle();
    end
    set_idle();
    next_cycle();
    mc_valid = 1'b1; mc_a = 32'd9; mc_b = 32'd3; mc_sign = 1'b0;
    $display("flush then DIVU 9/3 expect=00000003 latency=72");

    run_op(2'b00, 32'd100, 32'd7, 32'd14);
    run_op(2'b10, 32'd100, 32'd7, 32'd2);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/div_issue_ctrl.md
# div_issue_ctrl

Execute-stage initiator for the iterative `divider`. It does four things for RV32M DIV/DIVU/REM/REMU requests from EX:
- accepts the request and stalls the pipeline while the divider runs;
- drives the divider's start/operand/sign inputs and holds them stable until it finishes;
- resolves RISC-V special cases (divide-by-zero, signed overflow) locally without launching the divider;
- returns the selected 32-bit result with a one-cycle valid.

## Interface
- `WIDTH`, 32: operand/result width.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: EX holds a div/rem instruction. The request must stay stable while `stall`=1.
- `req_op` in 2: funct3[1:0]. 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- `req_rs1`, `req_rs2` in WIDTH: dividend, divisor.
- `flush` in 1: kill the in-flight request.
- `stall` out 1: hold the pipeline.
- `res_valid` out 1: single-cycle result strobe.
- `res_data` out WIDTH: result.
- `div_start` out 1: divider start pulse.
- `div_dividend`, `div_divisor` out WIDTH: divider operands.
- `div_sign` out 1: signed operation, equal to ~op[0].
- `div_busy` in 1: divider busy.
- `div_quotient`, `div_remainder` in WIDTH: divider results.

## Operation
- States: IDLE, ISSUE, WAIT, DONE, DRAIN.
- **IDLE**, `req_valid`=1 and `flush`=0: latch op/rs1/rs2.
  - Divisor==0 → DONE. Result: quotient 0xFFFFFFFF, remainder rs1 (signed and unsigned).
  - Signed op, rs1=0x80000000, rs2=0xFFFFFFFF → DONE. Result: quotient 0x80000000, remainder 0.
  - Otherwise → ISSUE.
- **ISSUE**: `div_start`=1 for exactly this cycle → WAIT.
- **WAIT**: on `div_busy`=0, capture the result → DONE. The result is `div_remainder` if op[1]=1, else `div_quotient`.
- **DONE**: `res_valid`=1, `res_data` valid, `stall`=0 → IDLE. A `req_valid` in the next cycle is a new instruction.
- `div_dividend`/`div_divisor`/`div_sign` are registered from the latched request. They are held unchanged from ISSUE until leaving WAIT/DRAIN, because the divider re-reads operand sign bits at its end.
- `stall` = `req_valid` & state≠DONE & ~`rst`. In DRAIN, `stall` = `req_valid`.
- **Flush**:
  - In ISSUE or WAIT → DRAIN. The divider cannot be aborted; wait for `div_busy`=0, then → IDLE. No `res_valid`.
  - In DONE: `res_valid` is still asserted; EX discards it.
  - In IDLE: request ignored.
  - If ISSUE is flushed, `div_start` is still asserted that cycle, so DRAIN waits for the full divider run.
- A request arriving during DRAIN waits. It is accepted in the IDLE cycle after the drain.

## Timing
- Normal path, with request first seen in IDLE at cycle 0:
  - ISSUE at cycle 1.
  - Divider CAL at cycles 2–33, END at 34, busy low at 35.
  - WAIT captures at 35; `res_valid` at cycle 36. Latency is 36 cycles.
- Special-case path and cache hit: `res_valid` at cycle 1.
- `div_busy` is high from cycle 2, so WAIT never samples a stale low.
- Reset values: state IDLE, `stall` 0, `res_valid` 0, `res_data` 0, `div_start` 0, `div_dividend` 0, `div_divisor` 0, `div_sign` 0, cache invalid.
- Reset mid-operation returns to IDLE immediately. The divider shares the reset domain; no result is emitted.

## Configuration
- `DIV_RESULT_CACHE_EN` defined: store {valid, rs1, rs2, sign, quotient, remainder} from the last completed, non-flushed divider run.
  - An IDLE request with matching rs1, rs2 and sign → DONE next cycle. The result is selected by op[1]; no `div_start` is issued.
  - This covers the DIV-then-REM pair.
  - Reset clears valid.
- Undefined: no cache storage; every non-special request runs the divider.

## Test plan
- DIVU 100/7: `div_start` pulses at cycle 1 only; `stall` is high cycles 0–35; `res_valid` at cycle 36 with 14. REMU 100/7 → 2.
- DIV -7/2 → 0xFFFFFFFD. REM -7/2 → 0xFFFFFFFF. DIV 7/-2 → 0xFFFFFFFD. REM 7/-2 → 1.
- DIV 5/0 → 0xFFFFFFFF at cycle 1, no `div_start`. REMU 5/0 → 5. DIVU 0/0 → 0xFFFFFFFF.
- DIV 0x80000000/0xFFFFFFFF → 0x80000000 at cycle 1. REM of the same operands → 0. DIVU of the same operands runs the divider → 0.
- `flush` at cycle 10 of DIVU 100/7: no `res_valid`. New DIVU 9/3 at cycle 20 keeps `stall` high until the drain ends (cycle 35). Its `div_start` follows 2 cycles later, and the result is 3.
- DIV 100/7 then REM 100/7: the REM returns 2 after 1 cycle with no `div_start` when `DIV_RESULT_CACHE_EN` is defined. Without it, the REM takes 36 cycles.
